mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  MEM-stage responder for the control word's read_memory/write_memory/wmask requests.
//  - Sequences data-memory port handshakes: word, byte (LDB/STB) and two-access indirect (LDI/STI).
//  - Returns load data and stalls the pipeline until the access retires.
//  - Sits between the EX/MEM pipeline register and the D-cache port.
// PARAMETERS
//  DATA_W  16  data width (lc3b_word)
//  ADDR_W  16  address width
// PORTS
//  clk              in   1       rising-edge clock (single clock domain)
//  rst_n            in   1       synchronous, active-low reset
//  valid_in         in   1       MEM stage holds a valid instruction
//  opcode           in   4       lc3b_opcode of MEM-stage instruction
//  read_memory      in   1       control-word load request
//  write_memory     in   1       control-word store request
//  byte_op          in   1       LDB/STB byte access (ldb_mux_sel | mem_wdata_b_sel)
//  addr_in          in   ADDR_W  effective address from ALU/adder
//  wdata_in         in   DATA_W  store data (SR)
//  dmem_resp        in   1       memory access complete
//  dmem_rdata       in   DATA_W  memory read data, valid with dmem_resp
//  dmem_read        out  1       memory read strobe
//  dmem_write       out  1       memory write strobe
//  dmem_address     out  ADDR_W  memory address
//  dmem_wdata       out  DATA_W  memory write data
//  dmem_byte_enable out  2       lane mask, [1]=high byte
//  rdata_out        out  DATA_W  load result to WB mux; held until next accepted request
//  mem_done         out  1       one-cycle pulse: access retired
//  stall            out  1       hold upstream stages
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=IDLE; latched addr/data/rdata_out=0.
//    All dmem_* strobes, mem_done and stall are 0 at the next cycle.
//  - Reset mid-access abandons the transfer; no completion pulse is generated.
//  - FSM states: IDLE, ACC1, GAP, ACC2, DONE.
//  - IDLE:
//    - req = valid_in & (read_memory | write_memory).
//    - When req=1: stall=1 combinationally; latch opcode/addr/wdata/byte_op/write; go to ACC1.
//    - When req=0: stall=0 and no strobes.
//  - ACC1:
//    - dmem_address = latched addr.
//    - LDI/STI or a read: dmem_read=1. Otherwise dmem_write=1.
//    - Stays in ACC1 until dmem_resp.
//    - On resp: LDI/STI latch dmem_rdata as pointer and go to GAP; all others latch the load result and go to DONE.
//  - GAP: one cycle with all strobes 0, then ACC2.
//  - ACC2:
//    - dmem_address = pointer.
//    - LDI: read. STI: write wdata, byte_enable=2'b11.
//    - On resp go to DONE (LDI latches the load result).
//  - DONE: mem_done=1, stall=0 (pipeline advances this edge); then IDLE.
//  - stall=1 in IDLE-with-req, ACC1, GAP and ACC2.
//    - Word access, resp in first ACC cycle: stall 2 cycles; total latency 3.
//  - Word ops: byte_enable=2'b11; address passed unmodified.
//  - Byte ops:
//    - byte_enable = addr[0] ? 2'b10 : 2'b01.
//    - STB: dmem_wdata = {wdata[7:0], wdata[7:0]}.
//    - LDB: rdata_out = ZEXT(selected byte) to 16 bits.
//  - read_memory & write_memory both 1: treated as a write; no read issued.
//  - After ACC1 entry, changes to valid_in or inputs are ignored (memory transfers are not abortable).
//  - Strobes stay high continuously while waiting for dmem_resp; dmem_resp outside ACC1/ACC2 is ignored.
// CONFIGURATION
//  MEM_STALL_CNT_EN defined:
//    - Adds output stall_cycles [31:0].
//    - Increments every cycle stall=1 and saturates at 32'hFFFF_FFFF.
//    - Reset to 0 by rst_n.
//  MEM_STALL_CNT_EN undefined: port and counter absent; otherwise identical.
// STRUCTURE
//  - lc3b_types additions:
//    - mem_ctrl_state_t enum {IDLE, ACC1, GAP, ACC2, DONE}.
//    - lc3b_byte_en typedef (logic [1:0]).
//    - Constants BE_WORD=2'b11, BE_LO=2'b01, BE_HI=2'b10.
//  - Sub-module mem_byte_lane (combinational): byte-enable generation, STB data replication, LDB byte select/ZEXT.
//  - FSM, request latches and optional counter stay in mem_access_ctrl.
// TESTING
//  1. LDR: addr=0x1234, resp same cycle, rdata=0xBEEF
//     -> dmem_read 1 cycle, be=11, rdata_out=0xBEEF, mem_done on cycle 3, stall 2 cycles.
//  2. STB: addr=0x2001, wdata=0x00A5, resp after 4 wait cycles
//     -> dmem_write held 5 cycles, be=10, wdata=0xA5A5, then mem_done.
//  3. LDB: addr=0x3000, rdata=0x80FF -> be=01, rdata_out=0x00FF.
//     Repeat at 0x3001 -> be=10, rdata_out=0x0080.
//  4. LDI: addr=0x4000 returns 0x5000; 0x5000 returns 0x1111
//     -> two reads with exactly one GAP cycle between them, second address=0x5000, rdata_out=0x1111.
//  5. STI: ptr 0x6000, wdata=0xCAFE
//     -> read 0x4000, GAP, write 0xCAFE to 0x6000 with be=11, mem_done once.
//  6. rst_n=0 during ACC2 of LDI
//     -> next cycle strobes=0, stall=0, state IDLE, no mem_done;
//     with MEM_STALL_CNT_EN, stall_cycles=0.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the MEM-stage access controller.
package mem_access_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, ACC1, GAP, ACC2, DONE} mem_ctrl_state_t;

  typedef logic [1:0] lc3b_byte_en;
  typedef logic [3:0] lc3b_opcode;

  localparam lc3b_byte_en BE_WORD = 2'b11;
  localparam lc3b_byte_en BE_LO   = 2'b01;
  localparam lc3b_byte_en BE_HI   = 2'b10;

  localparam lc3b_opcode OP_LDI = 4'b1010;
  localparam lc3b_opcode OP_STI = 4'b1011;

  // Indirect ops need a pointer fetch before the real access
  function automatic logic is_indirect(input lc3b_opcode op);
    return (op == OP_LDI) || (op == OP_STI);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side request/response and data-memory port bundle.
// master: the controller; slave: pipeline register + memory side.
interface mem_access_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  import mem_access_ctrl_pkg::*;

  logic              valid_in;
  lc3b_opcode        opcode;
  logic              read_memory;
  logic              write_memory;
  logic              byte_op;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] wdata_in;
  logic              dmem_resp;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_read;
  logic              dmem_write;
  logic [ADDR_W-1:0] dmem_address;
  logic [DATA_W-1:0] dmem_wdata;
  lc3b_byte_en       dmem_byte_enable;
  logic [DATA_W-1:0] rdata_out;
  logic              mem_done;
  logic              stall;

  modport master (
    input  valid_in, opcode, read_memory, write_memory, byte_op, addr_in, wdata_in,
    input  dmem_resp, dmem_rdata,
    output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    output rdata_out, mem_done, stall
  );

  modport slave (
    output valid_in, opcode, read_memory, write_memory, byte_op, addr_in, wdata_in,
    output dmem_resp, dmem_rdata,
    input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    input  rdata_out, mem_done, stall
  );

endinterface

// File: rtl/mem_access_ctrl_byte_lane.sv
// Byte-lane steering for LDB/STB: lane mask, store replication, load ZEXT.
module mem_byte_lane
  import mem_access_ctrl_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              i_byte_op,
  input  logic              i_addr_lsb,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_rdata,
  output lc3b_byte_en       o_be,
  output logic [DATA_W-1:0] o_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  // Word ops pass through; byte ops select the lane addressed by addr[0]
  always_comb begin
    o_be    = BE_WORD;
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    if (i_byte_op) begin
      o_be    = i_addr_lsb ? BE_HI : BE_LO;
      o_wdata = {(DATA_W/8){i_wdata[7:0]}};
      o_rdata = i_addr_lsb ? {{(DATA_W-8){1'b0}}, i_rdata[15:8]}
                           : {{(DATA_W-8){1'b0}}, i_rdata[7:0]};
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: word, byte and indirect (LDI/STI) accesses.
// Optional build macro MEM_STALL_CNT_EN adds a saturating stall_cycles counter.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_access_ctrl_if.master  bus
`ifdef MEM_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cycles
`endif
);

  mem_ctrl_state_t   r_state, w_state_next;
  logic              r_indirect, r_write, r_byte;
  logic [ADDR_W-1:0] r_addr, r_ptr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic              w_req, w_stall;
  lc3b_byte_en       w_lane_be;
  logic [DATA_W-1:0] w_lane_wdata, w_lane_rdata;

  assign w_req = bus.valid_in & (bus.read_memory | bus.write_memory);

  mem_byte_lane #(.DATA_W(DATA_W)) u_lane (
    .i_byte_op  (r_byte & ~r_indirect),
    .i_addr_lsb (r_addr[0]),
    .i_wdata    (r_wdata),
    .i_rdata    (bus.dmem_rdata),
    .o_be       (w_lane_be),
    .o_wdata    (w_lane_wdata),
    .o_rdata    (w_lane_rdata)
  );

  // Next state and memory-port strobes; strobes hold until dmem_resp
  always_comb begin
    w_state_next          = r_state;
    w_stall               = 1'b0;
    bus.dmem_read         = 1'b0;
    bus.dmem_write        = 1'b0;
    bus.dmem_address      = r_addr;
    bus.dmem_wdata        = r_wdata;
    bus.dmem_byte_enable  = BE_WORD;
    bus.mem_done          = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_stall = w_req;
        if (w_req) w_state_next = ACC1;
      end
      ACC1: begin
        w_stall = 1'b1;
        // Pointer fetch of STI is a read even though the op is a store
        if (r_indirect || !r_write) bus.dmem_read = 1'b1;
        else                        bus.dmem_write = 1'b1;
        bus.dmem_byte_enable = r_indirect ? BE_WORD : w_lane_be;
        bus.dmem_wdata       = w_lane_wdata;
        if (bus.dmem_resp) w_state_next = r_indirect ? GAP : DONE;
      end
      GAP: begin
        w_stall      = 1'b1;
        w_state_next = ACC2;
      end
      ACC2: begin
        w_stall          = 1'b1;
        bus.dmem_address = r_ptr;
        if (r_write) bus.dmem_write = 1'b1;
        else         bus.dmem_read  = 1'b1;
        if (bus.dmem_resp) w_state_next = DONE;
      end
      DONE: begin
        bus.mem_done = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign bus.stall     = w_stall;
  assign bus.rdata_out = r_rdata;

  // State register, request latches, pointer and load-result capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_indirect <= 1'b0;
      r_write    <= 1'b0;
      r_byte     <= 1'b0;
      r_addr     <= '0;
      r_ptr      <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && w_req) begin
        r_indirect <= is_indirect(bus.opcode);
        r_write    <= bus.write_memory;
        r_byte     <= bus.byte_op;
        r_addr     <= bus.addr_in;
        r_wdata    <= bus.wdata_in;
      end
      if (r_state == ACC1 && bus.dmem_resp) begin
        if (r_indirect)    r_ptr   <= bus.dmem_rdata;
        else if (!r_write) r_rdata <= w_lane_rdata;
      end
      if (r_state == ACC2 && bus.dmem_resp && !r_write) r_rdata <= bus.dmem_rdata;
    end
  end

`ifdef MEM_STALL_CNT_EN
  logic [31:0] r_stall_cycles;

  // Saturating count of cycles the pipeline was held
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_stall_cycles <= '0;
    else if (w_stall && r_stall_cycles != 32'hFFFF_FFFF)
      r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed cases plus randomized traffic checked
// cycle by cycle against a transaction-level memory model.
module tb_mem_access_ctrl;

  localparam logic [3:0] OP_LDB = 4'b0010, OP_STB = 4'b0011;
  localparam logic [3:0] OP_LDW = 4'b0110, OP_STW = 4'b0111;
  localparam logic [3:0] OP_LDI = 4'b1010, OP_STI = 4'b1011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.DATA_W(16), .ADDR_W(16)) bus();

`ifdef MEM_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  mem_access_ctrl #(.DATA_W(16), .ADDR_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MEM_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  // One cycle: inputs to drive plus outputs the model requires
  typedef struct {
    bit          rst;
    bit          valid, rm, wm, bop, resp;
    logic [3:0]  op;
    logic [15:0] addr, wdata, rdata;
    bit          e_rd, e_wr, e_done, e_stall, e_ld;
    logic [15:0] e_addr, e_wdata, e_rdata;
    logic [1:0]  e_be;
  } cyc_t;

  cyc_t exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [15:0] mem [logic [15:0]];

  int obs_stall, obs_done, obs_rd, obs_wr;
  logic [15:0] last_rd_addr, last_wr_addr, last_wr_wdata;
  logic [1:0]  last_rd_be, last_wr_be;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (!mem.exists(a)) mem[a] = 16'($urandom);
    return mem[a];
  endfunction

  // Idle cycle: random inputs that never form a request, all outputs quiet
  function automatic cyc_t blank();
    cyc_t c;
    c = '{default: '0};
    c.valid = 1'($urandom);
    c.op    = 4'($urandom);
    c.bop   = 1'($urandom);
    c.addr  = 16'($urandom);
    c.wdata = 16'($urandom);
    c.resp  = 1'($urandom);
    c.rdata = 16'($urandom);
    return c;
  endfunction

  // Busy cycle: inputs are don't-care to the DUT, so randomize them fully
  function automatic cyc_t noise();
    cyc_t c;
    c = blank();
    c.rm = 1'($urandom);
    c.wm = 1'($urandom);
    return c;
  endfunction

  task automatic drive(input cyc_t c);
    @(posedge clk);
    #1;
    rst_n            = !c.rst;
    bus.valid_in     = c.valid;
    bus.opcode       = c.op;
    bus.read_memory  = c.rm;
    bus.write_memory = c.wm;
    bus.byte_op      = c.bop;
    bus.addr_in      = c.addr;
    bus.wdata_in     = c.wdata;
    bus.dmem_resp    = c.resp;
    bus.dmem_rdata   = c.rdata;
    exp_q.push_back(c);
  endtask

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_obs();
    obs_stall = 0; obs_done = 0; obs_rd = 0; obs_wr = 0;
  endtask

  // Build the expected cycle sequence of one request from the memory model
  task automatic run_txn(input logic [3:0] op, input bit rm, input bit wm, input bit bop,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input int lat1, input int lat2, input int rst_idx);
    cyc_t c;
    bit ind, ld, rd1;
    logic [15:0] v, ptr, res;
    logic [1:0] be1;
    ind = (op == OP_LDI) || (op == OP_STI);
    ld  = rm && !wm;
    rd1 = ind || ld;
    res = '0;
    c = blank();
    c.valid = 1; c.op = op; c.rm = rm; c.wm = wm; c.bop = bop;
    c.addr = addr; c.wdata = wdata; c.e_stall = 1;
    drive(c);
    be1 = (bop && !ind) ? (addr[0] ? 2'b10 : 2'b01) : 2'b11;
    v = rd1 ? mem_rd(addr) : 16'h0;
    for (int k = 0; k <= lat1; k++) begin
      c = noise();
      c.e_stall = 1; c.e_rd = rd1; c.e_wr = !rd1;
      c.e_addr = addr; c.e_be = be1;
      c.e_wdata = (bop && !ind) ? {wdata[7:0], wdata[7:0]} : wdata;
      c.resp = (k == lat1);
      if (k == lat1 && rd1) c.rdata = v;
      drive(c);
    end
    if (!ind) begin
      if (wm) begin
        if (!mem.exists(addr)) mem[addr] = 16'($urandom);
        if (bop) begin
          if (addr[0]) mem[addr][15:8] = wdata[7:0];
          else         mem[addr][7:0]  = wdata[7:0];
        end else mem[addr] = wdata;
      end else
        res = bop ? {8'h00, (addr[0] ? v[15:8] : v[7:0])} : v;
    end else begin
      ptr = v;
      c = noise(); c.e_stall = 1;
      drive(c);
      v = ld ? mem_rd(ptr) : 16'h0;
      for (int k = 0; k <= lat2; k++) begin
        c = noise();
        c.e_stall = 1;
        if (k == rst_idx) begin
          c.rst = 1; c.resp = 0;
          drive(c);
          c = blank();
          drive(c);
          return;
        end
        c.e_rd = ld; c.e_wr = wm; c.e_addr = ptr; c.e_be = 2'b11; c.e_wdata = wdata;
        c.resp = (k == lat2);
        if (k == lat2 && ld) c.rdata = v;
        drive(c);
      end
      if (wm) mem[ptr] = wdata;
      else    res = v;
    end
    c = noise();
    c.valid = 0; c.e_done = 1; c.e_ld = ld; c.e_rdata = res;
    drive(c);
  endtask

  // Compare process: every queued cycle checked at the falling edge
  logic [15:0] m_rdata = '0;
  logic [31:0] m_cnt = '0;
  cyc_t e;
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.rst) begin
          m_rdata = '0;
          m_cnt   = '0;
        end else begin
          chk("stall", 32'(bus.stall), 32'(e.e_stall));
          chk("dmem_read", 32'(bus.dmem_read), 32'(e.e_rd));
          chk("dmem_write", 32'(bus.dmem_write), 32'(e.e_wr));
          chk("mem_done", 32'(bus.mem_done), 32'(e.e_done));
          if (e.e_rd || e.e_wr) begin
            chk("dmem_address", 32'(bus.dmem_address), 32'(e.e_addr));
            chk("dmem_byte_enable", 32'(bus.dmem_byte_enable), 32'(e.e_be));
          end
          if (e.e_wr) chk("dmem_wdata", 32'(bus.dmem_wdata), 32'(e.e_wdata));
          if (e.e_ld) m_rdata = e.e_rdata;
          chk("rdata_out", 32'(bus.rdata_out), 32'(m_rdata));
`ifdef MEM_STALL_CNT_EN
          chk("stall_cycles", stall_cycles, m_cnt);
`endif
          if (e.e_stall) m_cnt = m_cnt + 1;
          if (bus.stall) obs_stall++;
          if (bus.mem_done) obs_done++;
          if (bus.dmem_read) begin
            obs_rd++; last_rd_addr = bus.dmem_address; last_rd_be = bus.dmem_byte_enable;
          end
          if (bus.dmem_write) begin
            obs_wr++; last_wr_addr = bus.dmem_address;
            last_wr_wdata = bus.dmem_wdata; last_wr_be = bus.dmem_byte_enable;
          end
        end
      end
    end
  end

  initial begin
    cyc_t c;
    int kind, l1, l2, ri;
    logic [15:0] a;
    bus.valid_in = 0; bus.opcode = 0; bus.read_memory = 0; bus.write_memory = 0;
    bus.byte_op = 0; bus.addr_in = 0; bus.wdata_in = 0; bus.dmem_resp = 0; bus.dmem_rdata = 0;
    clr_obs();

    // Reset state
    for (int i = 0; i < 3; i++) begin
      c = blank(); c.rst = 1; drive(c);
    end
    c = blank(); drive(c);
    sync();
    chk("reset_stall", 32'(bus.stall), 32'h0);
    chk("reset_rdata", 32'(bus.rdata_out), 32'h0);
    chk("reset_read", 32'(bus.dmem_read | bus.dmem_write), 32'h0);

    // 1: LDR word, response in first access cycle
    mem[16'h1234] = 16'hBEEF; clr_obs();
    run_txn(OP_LDW, 1, 0, 0, 16'h1234, 16'h0, 0, 0, -1); sync();
    chk("t1_rdata", 32'(bus.rdata_out), 32'hBEEF);
    chk("t1_stall_cnt", obs_stall, 2);
    chk("t1_done_cnt", obs_done, 1);
    chk("t1_read_cnt", obs_rd, 1);
    chk("t1_be", 32'(last_rd_be), 32'h3);

    // 2: STB odd byte, four wait cycles
    clr_obs();
    run_txn(OP_STB, 0, 1, 1, 16'h2001, 16'h00A5, 4, 0, -1); sync();
    chk("t2_write_cnt", obs_wr, 5);
    chk("t2_be", 32'(last_wr_be), 32'h2);
    chk("t2_wdata", 32'(last_wr_wdata), 32'hA5A5);
    chk("t2_done_cnt", obs_done, 1);

    // 3: LDB both lanes
    mem[16'h3000] = 16'h80FF; mem[16'h3001] = 16'h80FF;
    run_txn(OP_LDB, 1, 0, 1, 16'h3000, 16'h0, 1, 0, -1); sync();
    chk("t3_lo_rdata", 32'(bus.rdata_out), 32'h00FF);
    chk("t3_lo_be", 32'(last_rd_be), 32'h1);
    run_txn(OP_LDB, 1, 0, 1, 16'h3001, 16'h0, 0, 0, -1); sync();
    chk("t3_hi_rdata", 32'(bus.rdata_out), 32'h0080);
    chk("t3_hi_be", 32'(last_rd_be), 32'h2);

    // 4: LDI
    mem[16'h4000] = 16'h5000; mem[16'h5000] = 16'h1111; clr_obs();
    run_txn(OP_LDI, 1, 0, 0, 16'h4000, 16'h0, 0, 0, -1); sync();
    chk("t4_rdata", 32'(bus.rdata_out), 32'h1111);
    chk("t4_addr2", 32'(last_rd_addr), 32'h5000);
    chk("t4_read_cnt", obs_rd, 2);
    chk("t4_stall_cnt", obs_stall, 4);

    // 5: STI
    mem[16'h4000] = 16'h6000; clr_obs();
    run_txn(OP_STI, 0, 1, 0, 16'h4000, 16'hCAFE, 0, 1, -1); sync();
    chk("t5_ptr_read", 32'(last_rd_addr), 32'h4000);
    chk("t5_waddr", 32'(last_wr_addr), 32'h6000);
    chk("t5_wdata", 32'(last_wr_wdata), 32'hCAFE);
    chk("t5_be", 32'(last_wr_be), 32'h3);
    chk("t5_done_cnt", obs_done, 1);

    // 6: reset while LDI waits in its second access
    mem[16'h4000] = 16'h5000; clr_obs();
    run_txn(OP_LDI, 1, 0, 0, 16'h4000, 16'h0, 0, 3, 1); sync();
    chk("t6_done_cnt", obs_done, 0);
    chk("t6_stall", 32'(bus.stall), 32'h0);
    chk("t6_rdata", 32'(bus.rdata_out), 32'h0);
`ifdef MEM_STALL_CNT_EN
    chk("t6_stall_cycles", stall_cycles, 32'h0);
`endif

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        c = blank(); drive(c);
      end
      kind = $urandom_range(0, 6);
      a  = {12'h700, 4'($urandom)};
      l1 = $urandom_range(0, 3);
      l2 = $urandom_range(0, 3);
      ri = ($urandom_range(0, 19) == 0) ? $urandom_range(0, l2) : -1;
      case (kind)
        0: run_txn(OP_LDW, 1, 0, 0, a, 16'($urandom), l1, l2, -1);
        1: run_txn(OP_STW, 0, 1, 0, a, 16'($urandom), l1, l2, -1);
        2: run_txn(OP_LDB, 1, 0, 1, a, 16'($urandom), l1, l2, -1);
        3: run_txn(OP_STB, 0, 1, 1, a, 16'($urandom), l1, l2, -1);
        4: run_txn(OP_LDI, 1, 0, 0, a, 16'($urandom), l1, l2, ri);
        5: run_txn(OP_STI, 0, 1, 0, a, 16'($urandom), l1, l2, ri);
        default: run_txn(OP_LDW, 1, 1, 0, a, 16'($urandom), l1, l2, -1);
      endcase
    end
    c = blank(); drive(c);
    sync();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
